// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: one-hot sequencer states,
// requester identifiers and the inactive level of each SRAM strobe.
package sram_arb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_RD   = 4'b0010,
        ST_WR   = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    localparam logic CEN_OFF = 1'b1;
    localparam logic WEN_OFF = 1'b1;
    localparam logic OEN_OFF = 1'b1;
    localparam logic DEN_OFF = 1'b0;

    // Wide enough for the largest cycle count (15); the counter never wraps.
    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_cyc_seq.sv
// SRAM cycle sequencer: runs one read or write with fixed strobe timing,
// then a one-cycle DONE for bus turnaround. All SRAM-facing outputs are flops.
module sram_cyc_seq
    import sram_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_CYC = 2,
    parameter int WR_CYC = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          done,
    output logic          idle,
    output logic          busy,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    input  logic [DW-1:0] sram_din,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic          sram_oen,
    output logic          sram_den
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] RD_LIM   = CNT_W'(RD_CYC);
    localparam logic [CNT_W-1:0] WR_LIM   = CNT_W'(WR_CYC);
    localparam logic [CNT_W-1:0] WEN_LAST = CNT_W'(WR_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             cen_q, cen_d;
    logic             wen_q, wen_d;
    logic             oen_q, oen_d;
    logic             den_q, den_d;
    logic             busy_q, busy_d;

    assign idle      = (state_q == ST_IDLE);
    assign busy      = busy_q;
    assign rdata     = rdata_q;
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;
    assign sram_cen  = cen_q;
    assign sram_wen  = wen_q;
    assign sram_oen  = oen_q;
    assign sram_den  = den_q;

    // Next state, cycle counter and next strobe levels (strobes idle unless a cycle continues).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        cen_d   = CEN_OFF;
        wen_d   = WEN_OFF;
        oen_d   = OEN_OFF;
        den_d   = DEN_OFF;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = addr;
                    dout_d = wdata;
                    cnt_d  = CNT_ONE;
                    cen_d  = 1'b0;
                    if (we) begin
                        // First write cycle is address/data setup: wen stays high.
                        state_d = ST_WR;
                        den_d   = 1'b1;
                    end else begin
                        state_d = ST_RD;
                        oen_d   = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q < RD_LIM) begin
                    cnt_d = cnt_q + CNT_ONE;
                    cen_d = 1'b0;
                    oen_d = 1'b0;
                end else begin
                    rdata_d = sram_din;
                    state_d = ST_DONE;
                    done    = 1'b1;
                end
            end
            ST_WR: begin
                if (cnt_q < WR_LIM) begin
                    cnt_d = cnt_q + CNT_ONE;
                    cen_d = 1'b0;
                    den_d = 1'b1;
                    // Write pulse only in the middle cycles; last cycle is data hold.
                    wen_d = ((cnt_d >= CNT_TWO) && (cnt_d <= WEN_LAST)) ? 1'b0 : WEN_OFF;
                end else begin
                    state_d = ST_DONE;
                    done    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered SRAM strobes/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            cen_q   <= CEN_OFF;
            wen_q   <= WEN_OFF;
            oen_q   <= OEN_OFF;
            den_q   <= DEN_OFF;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            oen_q   <= oen_d;
            den_q   <= den_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/sram_arb.sv
// Two-requester (CPU / loader) round-robin arbiter in front of the SRAM
// cycle sequencer. Owns the grant decision, owner tracking and ack routing.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_CYC = 2,
    parameter int WR_CYC = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    input  logic [DW-1:0] sram_din,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic          sram_oen,
    output logic          sram_den,
    output logic          busy
);

    logic          seq_done;
    logic          seq_idle;
    logic          start;
    logic          grant_ldr;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic owner_q, owner_d;
    logic last_grant_q, last_grant_d;
    logic cpu_ack_q, cpu_ack_d;
    logic ldr_ack_q, ldr_ack_d;

    assign cpu_ack = cpu_ack_q;
    assign ldr_ack = ldr_ack_q;

    // Round-robin grant, request mux, owner and ack/last-grant bookkeeping.
    always_comb begin
        // On a tie the loader wins only if the CPU was served last.
        grant_ldr = ldr_req & (~cpu_req | (last_grant_q == REQ_CPU));
        start     = seq_idle & (cpu_req | ldr_req);
        sel_we    = grant_ldr ? ldr_we    : cpu_we;
        sel_addr  = grant_ldr ? ldr_addr  : cpu_addr;
        sel_wdata = grant_ldr ? ldr_wdata : cpu_wdata;

        owner_d = owner_q;
        if (start) begin
            owner_d = grant_ldr ? REQ_LDR : REQ_CPU;
        end

        cpu_ack_d = seq_done & (owner_q == REQ_CPU);
        ldr_ack_d = seq_done & (owner_q == REQ_LDR);

        // The ack flops are high exactly in the DONE cycle.
        last_grant_d = last_grant_q;
        if (cpu_ack_q) begin
            last_grant_d = REQ_CPU;
        end else if (ldr_ack_q) begin
            last_grant_d = REQ_LDR;
        end
    end

    // Arbiter control registers; last_grant resets to LDR so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= REQ_CPU;
            last_grant_q <= REQ_LDR;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cpu_ack_q    <= cpu_ack_d;
            ldr_ack_q    <= ldr_ack_d;
        end
    end

    sram_cyc_seq #(
        .AW     (AW),
        .DW     (DW),
        .RD_CYC (RD_CYC),
        .WR_CYC (WR_CYC)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .we        (sel_we),
        .addr      (sel_addr),
        .wdata     (sel_wdata),
        .done      (seq_done),
        .idle      (seq_idle),
        .busy      (busy),
        .rdata     (rdata),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .sram_din  (sram_din),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_oen  (sram_oen),
        .sram_den  (sram_den)
    );

endmodule

// File: tb/tb_sram_arb.sv
// Directed testbench for sram_arb: default-parameter instance (a_*) plus a
// RD_CYC=4 / WR_CYC=5 instance (b_*), each with a small SRAM model.
module tb_sram_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_cpu_req, a_cpu_we, a_cpu_ack, a_ldr_req, a_ldr_we, a_ldr_ack;
    logic [7:0] a_cpu_addr, a_cpu_wdata, a_ldr_addr, a_ldr_wdata;
    logic [7:0] a_rdata, a_sram_addr, a_sram_dout, a_sram_din;
    logic       a_cen, a_wen, a_oen, a_den, a_busy;

    logic       b_cpu_req, b_cpu_we, b_cpu_ack, b_ldr_req, b_ldr_we, b_ldr_ack;
    logic [7:0] b_cpu_addr, b_cpu_wdata, b_ldr_addr, b_ldr_wdata;
    logic [7:0] b_rdata, b_sram_addr, b_sram_dout, b_sram_din;
    logic       b_cen, b_wen, b_oen, b_den, b_busy;

    sram_arb dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack),
        .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr), .ldr_wdata(a_ldr_wdata), .ldr_ack(a_ldr_ack),
        .rdata(a_rdata), .sram_addr(a_sram_addr), .sram_dout(a_sram_dout), .sram_din(a_sram_din),
        .sram_cen(a_cen), .sram_wen(a_wen), .sram_oen(a_oen), .sram_den(a_den), .busy(a_busy)
    );

    sram_arb #(.RD_CYC(4), .WR_CYC(5)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata), .ldr_ack(b_ldr_ack),
        .rdata(b_rdata), .sram_addr(b_sram_addr), .sram_dout(b_sram_dout), .sram_din(b_sram_din),
        .sram_cen(b_cen), .sram_wen(b_wen), .sram_oen(b_oen), .sram_den(b_den), .busy(b_busy)
    );

    // SRAM models: unwritten locations read as addr ^ 0x99 (so 0x3C reads 0xA5).
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    bit         wr_a  [256];
    bit         wr_b  [256];

    assign a_sram_din = (!a_cen && !a_oen) ? (wr_a[a_sram_addr] ? mem_a[a_sram_addr] : (a_sram_addr ^ 8'h99)) : 8'hxx;
    assign b_sram_din = (!b_cen && !b_oen) ? (wr_b[b_sram_addr] ? mem_b[b_sram_addr] : (b_sram_addr ^ 8'h99)) : 8'hxx;

    always @(posedge clk) begin
        if (a_cen === 1'b0 && a_wen === 1'b0 && a_den === 1'b1) begin
            mem_a[a_sram_addr] <= a_sram_dout;
            wr_a[a_sram_addr]  <= 1'b1;
        end
        if (b_cen === 1'b0 && b_wen === 1'b0 && b_den === 1'b1) begin
            mem_b[b_sram_addr] <= b_sram_dout;
            wr_b[b_sram_addr]  <= 1'b1;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int n_inv = 0;

    // Bus invariants on both instances, all tests.
    always @(negedge clk) begin
        if (a_wen === 1'b0 && a_oen === 1'b0) begin
            n_inv++;
            $display("FAIL inv_a_wen_oen: wen=%b oen=%b both low at %0t", a_wen, a_oen, $time);
        end
        if (b_wen === 1'b0 && b_oen === 1'b0) begin
            n_inv++;
            $display("FAIL inv_b_wen_oen: wen=%b oen=%b both low at %0t", b_wen, b_oen, $time);
        end
        if (a_den === 1'b1 && a_cen !== 1'b0) begin
            n_inv++;
            $display("FAIL inv_a_den: den=%b with cen=%b at %0t", a_den, a_cen, $time);
        end
        if (b_den === 1'b1 && b_cen !== 1'b0) begin
            n_inv++;
            $display("FAIL inv_b_den: den=%b with cen=%b at %0t", b_den, b_cen, $time);
        end
    end

    // Per-cycle capture (index k = cycles after the request cycle).
    logic       cen_tr [64];
    logic       wen_tr [64];
    logic       oen_tr [64];
    logic       den_tr [64];
    logic       cack_tr[64];
    logic       lack_tr[64];
    logic       busy_tr[64];
    logic [7:0] addr_tr[64];
    logic [7:0] rd_tr  [64];

    task automatic capture(input int n, input bit sel_b, input bit auto_drop);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (!sel_b) begin
                cen_tr[k] = a_cen;  wen_tr[k] = a_wen;  oen_tr[k] = a_oen;  den_tr[k] = a_den;
                cack_tr[k] = a_cpu_ack; lack_tr[k] = a_ldr_ack; busy_tr[k] = a_busy;
                addr_tr[k] = a_sram_addr; rd_tr[k] = a_rdata;
                if (auto_drop && a_cpu_ack) a_cpu_req = 1'b0;
                if (auto_drop && a_ldr_ack) a_ldr_req = 1'b0;
            end else begin
                cen_tr[k] = b_cen;  wen_tr[k] = b_wen;  oen_tr[k] = b_oen;  den_tr[k] = b_den;
                cack_tr[k] = b_cpu_ack; lack_tr[k] = b_ldr_ack; busy_tr[k] = b_busy;
                addr_tr[k] = b_sram_addr; rd_tr[k] = b_rdata;
                if (auto_drop && b_cpu_ack) b_cpu_req = 1'b0;
                if (auto_drop && b_ldr_ack) b_ldr_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({a_cen, a_wen, a_oen, a_den} !== 4'b1110) begin n_err++;
            $display("FAIL reset_a_strobes: got cen/wen/oen/den=%b want 1110", {a_cen, a_wen, a_oen, a_den}); end
        n_vec++; if ({a_cpu_ack, a_ldr_ack, a_busy} !== 3'b000) begin n_err++;
            $display("FAIL reset_a_ctrl: got acks/busy=%b want 000", {a_cpu_ack, a_ldr_ack, a_busy}); end
        n_vec++; if ({a_sram_addr, a_sram_dout, a_rdata} !== 24'h0) begin n_err++;
            $display("FAIL reset_a_data: got addr/dout/rdata=%h want 000000", {a_sram_addr, a_sram_dout, a_rdata}); end
        n_vec++; if ({b_cen, b_wen, b_oen, b_den, b_busy, b_cpu_ack, b_ldr_ack} !== 7'b1110000) begin n_err++;
            $display("FAIL reset_b_ctrl: got %b want 1110000", {b_cen, b_wen, b_oen, b_den, b_busy, b_cpu_ack, b_ldr_ack}); end
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        a_cpu_we = 1'b0; a_cpu_addr = 8'h3C; a_cpu_req = 1'b1;
        capture(6, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            n_vec++; if ({cen_tr[k], oen_tr[k], wen_tr[k], den_tr[k]} !== {(k > 2), (k > 2), 1'b1, 1'b0}) begin n_err++;
                $display("FAIL cpu_read_strobes[%0d]: got cen/oen/wen/den=%b want %b", k,
                         {cen_tr[k], oen_tr[k], wen_tr[k], den_tr[k]}, {(k > 2), (k > 2), 1'b1, 1'b0}); end
            n_vec++; if ({cack_tr[k], lack_tr[k]} !== {(k == 3), 1'b0}) begin n_err++;
                $display("FAIL cpu_read_ack[%0d]: got cpu/ldr ack=%b want %b", k, {cack_tr[k], lack_tr[k]}, {(k == 3), 1'b0}); end
        end
        for (int k = 1; k <= 3; k++) begin
            n_vec++; if (addr_tr[k] !== 8'h3C) begin n_err++;
                $display("FAIL cpu_read_addr[%0d]: got %h want 3c", k, addr_tr[k]); end
        end
        n_vec++; if (rd_tr[3] !== 8'hA5) begin n_err++;
            $display("FAIL cpu_read_rdata: got %h want a5", rd_tr[3]); end
        n_vec++; if ({busy_tr[1], busy_tr[3], busy_tr[4]} !== 3'b110) begin n_err++;
            $display("FAIL cpu_read_busy: got %b want 110", {busy_tr[1], busy_tr[3], busy_tr[4]}); end
    endtask

    task automatic test_ldr_write();
        a_ldr_we = 1'b1; a_ldr_addr = 8'h10; a_ldr_wdata = 8'h5A; a_ldr_req = 1'b1;
        capture(7, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            n_vec++; if ({cen_tr[k], den_tr[k], wen_tr[k], oen_tr[k]} !== {(k > 3), (k <= 3), (k != 2), 1'b1}) begin n_err++;
                $display("FAIL ldr_write_strobes[%0d]: got cen/den/wen/oen=%b want %b", k,
                         {cen_tr[k], den_tr[k], wen_tr[k], oen_tr[k]}, {(k > 3), (k <= 3), (k != 2), 1'b1}); end
            n_vec++; if ({cack_tr[k], lack_tr[k]} !== {1'b0, (k == 4)}) begin n_err++;
                $display("FAIL ldr_write_ack[%0d]: got cpu/ldr ack=%b want %b", k, {cack_tr[k], lack_tr[k]}, {1'b0, (k == 4)}); end
        end
        n_vec++; if (!wr_a[8'h10] || mem_a[8'h10] !== 8'h5A) begin n_err++;
            $display("FAIL ldr_write_mem: got %h (written=%0d) want 5a", mem_a[8'h10], wr_a[8'h10]); end
        n_vec++; if (a_rdata !== 8'hA5) begin n_err++;
            $display("FAIL ldr_write_rdata_hold: got %h want a5", a_rdata); end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_cpu_we = 1'b0; a_cpu_addr = 8'h01; a_cpu_req = 1'b1;
        a_ldr_we = 1'b1; a_ldr_addr = 8'h02; a_ldr_wdata = 8'h77; a_ldr_req = 1'b1;
        capture(10, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            n_vec++; if ({cack_tr[k], lack_tr[k]} !== {(k == 3), (k == 8)}) begin n_err++;
                $display("FAIL simul_ack[%0d]: got cpu/ldr ack=%b want %b", k, {cack_tr[k], lack_tr[k]}, {(k == 3), (k == 8)}); end
            n_vec++; if (cen_tr[k] !== !((k >= 1 && k <= 2) || (k >= 5 && k <= 7))) begin n_err++;
                $display("FAIL simul_cen[%0d]: got %b want %b", k, cen_tr[k], !((k >= 1 && k <= 2) || (k >= 5 && k <= 7))); end
        end
        n_vec++; if (rd_tr[3] !== 8'h98) begin n_err++;
            $display("FAIL simul_rdata: got %h want 98", rd_tr[3]); end
        n_vec++; if (mem_a[8'h02] !== 8'h77) begin n_err++;
            $display("FAIL simul_mem: got %h want 77", mem_a[8'h02]); end
    endtask

    task automatic test_back_to_back();
        int ord[16];
        int n_ord;
        n_ord = 0;
        a_cpu_we = 1'b0; a_cpu_addr = 8'h01; a_cpu_req = 1'b1;
        a_ldr_we = 1'b1; a_ldr_addr = 8'h02; a_ldr_wdata = 8'h44; a_ldr_req = 1'b1;
        capture(27, 1'b0, 1'b0);
        a_cpu_req = 1'b0; a_ldr_req = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            if (cack_tr[k] === 1'b1 && n_ord < 16) begin ord[n_ord] = 0; n_ord++; end
            if (lack_tr[k] === 1'b1 && n_ord < 16) begin ord[n_ord] = 1; n_ord++; end
        end
        n_vec++; if (n_ord != 6) begin n_err++;
            $display("FAIL b2b_count: got %0d acks want 6", n_ord); end
        for (int i = 0; i < 6 && i < n_ord; i++) begin
            n_vec++; if (ord[i] != (i % 2)) begin n_err++;
                $display("FAIL b2b_order[%0d]: got %s want %s", i, ord[i] ? "LDR" : "CPU", (i % 2) ? "LDR" : "CPU"); end
        end
        n_vec++; if ({cack_tr[21], lack_tr[26]} !== 2'b11) begin n_err++;
            $display("FAIL b2b_timing: got cack@21/lack@26=%b want 11", {cack_tr[21], lack_tr[26]}); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_write();
        a_ldr_we = 1'b1; a_ldr_addr = 8'h20; a_ldr_wdata = 8'h99; a_ldr_req = 1'b1;
        capture(2, 1'b0, 1'b0);
        n_vec++; if (wen_tr[2] !== 1'b0) begin n_err++;
            $display("FAIL midrst_in_wr2: got wen=%b want 0", wen_tr[2]); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if ({a_cen, a_wen, a_oen, a_den, a_busy, a_cpu_ack, a_ldr_ack} !== 7'b1110000) begin n_err++;
            $display("FAIL midrst_state: got cen/wen/oen/den/busy/cack/lack=%b want 1110000",
                     {a_cen, a_wen, a_oen, a_den, a_busy, a_cpu_ack, a_ldr_ack}); end
        rst = 1'b0;
        capture(6, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            n_vec++; if ({lack_tr[k], cack_tr[k], cen_tr[k], wen_tr[k]} !== {(k == 4), 1'b0, (k > 3), (k != 2)}) begin n_err++;
                $display("FAIL midrst_regrant[%0d]: got lack/cack/cen/wen=%b want %b", k,
                         {lack_tr[k], cack_tr[k], cen_tr[k], wen_tr[k]}, {(k == 4), 1'b0, (k > 3), (k != 2)}); end
        end
        n_vec++; if (mem_a[8'h20] !== 8'h99) begin n_err++;
            $display("FAIL midrst_mem: got %h want 99", mem_a[8'h20]); end
    endtask

    task automatic test_param_sweep();
        b_cpu_we = 1'b0; b_cpu_addr = 8'h05; b_cpu_req = 1'b1;
        capture(8, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            n_vec++; if ({cen_tr[k], oen_tr[k], wen_tr[k], cack_tr[k], lack_tr[k]} !== {(k > 4), (k > 4), 1'b1, (k == 5), 1'b0}) begin n_err++;
                $display("FAIL sweep_read[%0d]: got cen/oen/wen/cack/lack=%b want %b", k,
                         {cen_tr[k], oen_tr[k], wen_tr[k], cack_tr[k], lack_tr[k]}, {(k > 4), (k > 4), 1'b1, (k == 5), 1'b0}); end
        end
        n_vec++; if (rd_tr[5] !== 8'h9C) begin n_err++;
            $display("FAIL sweep_rdata: got %h want 9c", rd_tr[5]); end
        b_cpu_we = 1'b1; b_cpu_addr = 8'h06; b_cpu_wdata = 8'h3E; b_cpu_req = 1'b1;
        capture(9, 1'b1, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            n_vec++; if ({cen_tr[k], den_tr[k], wen_tr[k], cack_tr[k]} !== {(k > 5), (k <= 5), !(k >= 2 && k <= 4), (k == 6)}) begin n_err++;
                $display("FAIL sweep_write[%0d]: got cen/den/wen/cack=%b want %b", k,
                         {cen_tr[k], den_tr[k], wen_tr[k], cack_tr[k]}, {(k > 5), (k <= 5), !(k >= 2 && k <= 4), (k == 6)}); end
        end
        n_vec++; if (mem_b[8'h06] !== 8'h3E) begin n_err++;
            $display("FAIL sweep_mem: got %h want 3e", mem_b[8'h06]); end
    endtask

    initial begin
        a_cpu_req = 1'b0; a_cpu_we = 1'b0; a_cpu_addr = 8'h00; a_cpu_wdata = 8'h00;
        a_ldr_req = 1'b0; a_ldr_we = 1'b0; a_ldr_addr = 8'h00; a_ldr_wdata = 8'h00;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 8'h00; b_cpu_wdata = 8'h00;
        b_ldr_req = 1'b0; b_ldr_we = 1'b0; b_ldr_addr = 8'h00; b_ldr_wdata = 8'h00;
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_write();
        test_param_sweep();
        repeat (2) @(posedge clk);
        #1;
        n_err += n_inv;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arb.md
Name: sram_arb

Overview:
- Two-requester arbiter and cycle sequencer for the single external asynchronous SRAM.
- Requesters:
  - CPU: the memory side of the instruction/data path.
  - Loader: a program-load/debug port that writes or reads memory while the CPU runs or is held.
- Grants one requester at a time using round-robin order.
- Drives SRAM strobes (cen, wen, oen, den) with fixed, parameterised read and write timing.
- Returns read data with a one-cycle ack pulse.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- RD_CYC, 2, cycles with cen/oen low per read. Range 1..15.
- WR_CYC, 3, cycles with cen low and den high per write. Range 3..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- cpu_req  in  1  CPU access request. Level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read. Sampled at grant.
- cpu_addr  in  AW  CPU address. Sampled at grant.
- cpu_wdata  in  DW  CPU write data. Sampled at grant.
- cpu_ack  out  1  one-cycle pulse when the CPU access completes.
- ldr_req  in  1  loader request. Same rules as cpu_req.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_ack  out  1  one-cycle pulse when the loader access completes.
- rdata  out  DW  read data. Valid in the ack cycle; held until the next read completes.
- sram_addr  out  AW  SRAM address.
- sram_dout  out  DW  data driven toward SRAM; qualified by sram_den.
- sram_din  in  DW  data from SRAM.
- sram_cen  out  1  chip enable, active low.
- sram_wen  out  1  write enable, active low.
- sram_oen  out  1  output enable, active low.
- sram_den  out  1  data-drive enable, active high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Every output is a register.
- Reset values:
  - cen = wen = oen = 1; den = 0.
  - cpu_ack = ldr_ack = 0; busy = 0.
  - sram_addr, sram_dout, rdata = 0.
  - State = IDLE, last_grant = LDR, so the CPU wins the first tie.
- Reset mid-access: the next edge forces IDLE, all strobes inactive, no ack issued. The pending request is re-arbitrated after reset.
- State machine, one-hot: IDLE, RD, WR, DONE. A cycle counter cnt tracks progress within RD and WR.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On grant: latch addr, wdata and we into sram_addr/sram_dout; set owner; cnt = 1; go to RD (we = 0) or WR (we = 1).
  - With no request, stay in IDLE.
- RD:
  - cen = 0, oen = 0, wen = 1, den = 0.
  - While cnt < RD_CYC, increment cnt.
  - On the edge leaving cnt == RD_CYC: rdata <= sram_din; go to DONE.
- WR:
  - cen = 0 and den = 1 for all WR_CYC cycles.
  - wen = 0 only for cycles 2..WR_CYC-1. This gives one cycle of address/data setup and one cycle of hold.
  - After cycle WR_CYC, go to DONE.
- DONE:
  - One cycle. All strobes inactive (bus turnaround).
  - The owner's ack = 1; last_grant <= owner.
  - Next state is IDLE.
- Latency, counted from req first seen in IDLE (cycle 0) to ack: RD_CYC+1 cycles for reads, WR_CYC+1 for writes. Peak throughput is one access per RD_CYC+2 or WR_CYC+2 cycles.
- Requester rules:
  - Hold req and its fields stable until ack.
  - Deassert req in the cycle after ack. A req still high in that IDLE cycle is a new request.
- Interface invariants:
  - No glitch or overlap: wen and oen are never low together.
  - den = 1 only in WR.
  - sram_addr is stable for the whole RD/WR phase and through DONE.
  - The non-granted requester's ack stays 0.
  - Fairness: under continuous dual requests, grants alternate CPU, LDR, CPU, ...
- Counter: 4 bits, wide enough for the maximum parameter value of 15. It never wraps, because it is bounded by RD_CYC/WR_CYC.

Decomposition:
- Package sram_arb_pkg:
  - One-hot state constants (IDLE, RD, WR, DONE).
  - Requester ID constants (REQ_CPU = 0, REQ_LDR = 1).
  - Strobe idle levels.
- Sub-module sram_cyc_seq:
  - Contains the RD/WR/DONE sequencer, the counter and the strobe registers.
  - Takes start, we, addr and wdata; returns done and rdata.
- The top level keeps the round-robin arbiter, owner/last_grant registers and ack routing.

Test Plan:
- CPU read, defaults: preload SRAM model [0x3C] = 0xA5; cpu_req with addr 0x3C; ldr idle -> cen/oen low for exactly 2 cycles, wen = 1 throughout, cpu_ack pulses at cycle 3, rdata = 0xA5, ldr_ack = 0.
- Loader write: ldr_req, we = 1, addr 0x10, wdata 0x5A -> cen low and den high for 3 cycles, wen low only in cycle 2; memory[0x10] = 0x5A; ldr_ack at cycle 4.
- Simultaneous requests after reset: CPU read 0x01 and LDR write 0x02 = 0x77 -> CPU is served first, then LDR with no idle gap beyond one IDLE cycle. Hold both reqs continuously for 6 accesses -> grant order C, L, C, L, C, L.
- Reset mid-write: assert rst during WR cycle 2 -> next edge: cen = wen = 1, den = 0, busy = 0, no ack. After release, the held request is regranted and completes normally.
- Parameter sweep RD_CYC = 4, WR_CYC = 5 -> read ack at cycle 5, write ack at cycle 6. wen is low for cycles 2..4. wen and oen are never low simultaneously, checked by assertion across all tests.
